// File: rtl/bcd_7seg_scanner.sv
// bcd_7seg_scanner
//   Time-multiplexed 7-segment driver for packed BCD score digits. One digit
//   is scanned per refresh slot; all digits and decimal points are captured
//   into a shadow copy once per frame so counter ripple never tears the
//   displayed value. Supports leading-zero blanking, a dash for invalid BCD
//   codes, and PWM dimming within each slot.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-low
//   bcd_in      packed BCD digits, [3:0] = digit 0 (least significant)
//   dp_in       decimal point request per digit
//   brightness  PWM level, 0 = dimmest, 15 = full
//   seg         segments, bit0 = a .. bit6 = g
//   dp          decimal point segment
//   an          digit enables, bit k selects digit k
//   frame_tick  one-cycle pulse when a new snapshot is loaded
module bcd_7seg_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int ACTIVE_LOW_OUT = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  // p*16 and (brightness+1)*REFRESH_DIV both fit in PW+5 bits
  localparam int unsigned LW = PW + 5;
  localparam logic        INV    = (ACTIVE_LOW_OUT != 0);
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [LW-1:0] DIV_W  = LW'(REFRESH_DIV);

  logic [PW-1:0]           p;
  logic [IW-1:0]           i;
  logic [4*NUM_DIGITS-1:0] sh_bcd;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic                    primed;

  logic                  p_wrap;
  logic                  frame_end;
  logic                  lit;
  logic [LW-1:0]         p_scaled;
  logic [LW-1:0]         thresh;
  logic [3:0]            cur;
  logic [6:0]            pat;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] onehot;

  always_comb begin
    p_wrap    = (p == P_LAST);
    frame_end = p_wrap && (i == I_LAST);

    // Lit when past the anti-ghost cycle and inside the PWM window
    p_scaled = {1'b0, p, 4'b0000};
    thresh   = (LW'(brightness) + LW'(1)) * DIV_W;
    lit      = (p != '0) && (p_scaled < thresh);

    cur = sh_bcd[i*4 +: 4];
    unique case (cur)
      4'd0:    pat = 7'b0111111;
      4'd1:    pat = 7'b0000110;
      4'd2:    pat = 7'b1011011;
      4'd3:    pat = 7'b1001111;
      4'd4:    pat = 7'b1100110;
      4'd5:    pat = 7'b1101101;
      4'd6:    pat = 7'b1111101;
      4'd7:    pat = 7'b0000111;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1101111;
      default: pat = 7'b1000000;
    endcase

    // Walk down from the top digit; a digit is blanked while every digit
    // at or above it is exactly zero. Digit 0 is never blanked.
    blank    = '0;
    zero_run = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (sh_bcd[k*4 +: 4] == 4'd0);
      blank[k] = (BLANK_LEADING != 0) && zero_run;
    end

    onehot = NUM_DIGITS'(1) << i;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      p          <= '0;
      i          <= '0;
      sh_bcd     <= '0;
      sh_dp      <= '0;
      primed     <= 1'b0;
      frame_tick <= 1'b0;
      seg        <= {7{INV}};
      dp         <= INV;
      an         <= {NUM_DIGITS{INV}};
    end else begin
      p <= p_wrap ? '0 : p + 1'b1;
      if (p_wrap) begin
        i <= (i == I_LAST) ? '0 : i + 1'b1;
      end

      frame_tick <= 1'b0;
      if (!primed || frame_end) begin
        sh_bcd     <= bcd_in;
        sh_dp      <= dp_in;
        primed     <= 1'b1;
        frame_tick <= 1'b1;
      end

      an  <= (lit ? onehot : '0) ^ {NUM_DIGITS{INV}};
      seg <= ((lit && !blank[i]) ? pat : 7'd0) ^ {7{INV}};
      dp  <= (lit && sh_dp[i]) ^ INV;
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
module tb_bcd_7seg_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  brightness = 4'd15;

  logic [6:0] seg, nb_seg, al_seg;
  logic       dp, nb_dp, al_dp;
  logic [3:0] an, nb_an, al_an;
  logic       frame_tick, nb_ft, al_ft;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_7seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(32), .ACTIVE_LOW_OUT(0), .BLANK_LEADING(1)) dut (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .dp_in(dp_in), .brightness(brightness),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick));

  bcd_7seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(32), .ACTIVE_LOW_OUT(0), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .dp_in(dp_in), .brightness(brightness),
    .seg(nb_seg), .dp(nb_dp), .an(nb_an), .frame_tick(nb_ft));

  bcd_7seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(32), .ACTIVE_LOW_OUT(1), .BLANK_LEADING(1)) dut_al (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .dp_in(dp_in), .brightness(brightness),
    .seg(al_seg), .dp(al_dp), .an(al_an), .frame_tick(al_ft));

  // Leaves reset=1 at a falling edge; the next rising edge is released cycle 1.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bcd_in = 16'h1234; dp_in = 4'hF; brightness = 4'd15;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({an, seg, dp, frame_tick} !== 13'b0) begin
      n_bad++;
      $display("FAIL reset_main: got an=%b seg=%b dp=%b ft=%b, want all 0", an, seg, dp, frame_tick);
    end
    n_cmp++;
    if ({nb_an, nb_seg, nb_dp, nb_ft} !== 13'b0) begin
      n_bad++;
      $display("FAIL reset_nb: got an=%b seg=%b dp=%b ft=%b, want all 0", nb_an, nb_seg, nb_dp, nb_ft);
    end
    n_cmp++;
    if ({al_an, al_seg, al_dp} !== 12'hFFF) begin
      n_bad++;
      $display("FAIL reset_al_pins: got an=%b seg=%b dp=%b, want all 1", al_an, al_seg, al_dp);
    end
    n_cmp++;
    if (al_ft !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_al_ft: got %b, want 0", al_ft);
    end
  endtask

  // 1234 at full brightness across two frames
  task automatic test_scan();
    logic [6:0] es [4];
    logic [3:0] ea;
    logic [6:0] eseg;
    logic       eft;
    int pp, ii;
    es = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
    bcd_in = 16'h1234; dp_in = 4'h0; brightness = 4'd15;
    do_reset();
    for (int n = 1; n <= 257; n++) begin
      @(negedge clk);
      pp = (n - 1) % 32;
      ii = ((n - 1) / 32) % 4;
      ea   = (pp != 0) ? (4'b0001 << ii) : 4'b0000;
      eseg = (pp != 0) ? es[ii] : 7'd0;
      eft  = (n == 1) || (n == 128) || (n == 256);
      n_cmp++;
      if (an !== ea) begin n_bad++; $display("FAIL scan_an n=%0d: got %b, want %b", n, an, ea); end
      n_cmp++;
      if (seg !== eseg) begin n_bad++; $display("FAIL scan_seg n=%0d: got %b, want %b", n, seg, eseg); end
      n_cmp++;
      if (dp !== 1'b0) begin n_bad++; $display("FAIL scan_dp n=%0d: got %b, want 0", n, dp); end
      n_cmp++;
      if (frame_tick !== eft) begin n_bad++; $display("FAIL scan_ft n=%0d: got %b, want %b", n, frame_tick, eft); end
      n_cmp++;
      if (nb_seg !== eseg) begin n_bad++; $display("FAIL scan_nb_seg n=%0d: got %b, want %b", n, nb_seg, eseg); end
      n_cmp++;
      if ({al_an, al_seg, al_dp} !== ~{ea, eseg, 1'b0}) begin
        n_bad++;
        $display("FAIL scan_al n=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=1", n, al_an, al_seg, al_dp, ~ea, ~eseg);
      end
    end
  endtask

  // 0007 with dp on digit 2; blanked and unblanked variants
  task automatic test_blank();
    logic [6:0] es [4];
    logic [6:0] en [4];
    logic [3:0] ea;
    logic [6:0] eseg, enb;
    logic       edp;
    int pp, ii;
    es = '{7'b0000111, 7'd0, 7'd0, 7'd0};
    en = '{7'b0000111, 7'b0111111, 7'b0111111, 7'b0111111};
    bcd_in = 16'h0007; dp_in = 4'b0100; brightness = 4'd15;
    do_reset();
    for (int n = 1; n <= 128; n++) begin
      @(negedge clk);
      pp = (n - 1) % 32;
      ii = (n - 1) / 32;
      ea   = (pp != 0) ? (4'b0001 << ii) : 4'b0000;
      eseg = (pp != 0) ? es[ii] : 7'd0;
      enb  = (pp != 0) ? en[ii] : 7'd0;
      edp  = (pp != 0) && (ii == 2);
      n_cmp++;
      if (an !== ea) begin n_bad++; $display("FAIL blank_an n=%0d: got %b, want %b", n, an, ea); end
      n_cmp++;
      if (seg !== eseg) begin n_bad++; $display("FAIL blank_seg n=%0d: got %b, want %b", n, seg, eseg); end
      n_cmp++;
      if (dp !== edp) begin n_bad++; $display("FAIL blank_dp n=%0d: got %b, want %b", n, dp, edp); end
      n_cmp++;
      if (nb_seg !== enb) begin n_bad++; $display("FAIL blank_nb_seg n=%0d: got %b, want %b", n, nb_seg, enb); end
      n_cmp++;
      if (nb_dp !== edp) begin n_bad++; $display("FAIL blank_nb_dp n=%0d: got %b, want %b", n, nb_dp, edp); end
    end
  endtask

  // 00A0: dash in digit 1, digit 0 zero stays visible
  task automatic test_dash();
    logic [6:0] es [4];
    logic [6:0] en [4];
    logic [6:0] eseg, enb;
    int pp, ii;
    es = '{7'b0111111, 7'b1000000, 7'd0, 7'd0};
    en = '{7'b0111111, 7'b1000000, 7'b0111111, 7'b0111111};
    bcd_in = 16'h00A0; dp_in = 4'h0; brightness = 4'd15;
    do_reset();
    for (int n = 1; n <= 128; n++) begin
      @(negedge clk);
      pp = (n - 1) % 32;
      ii = (n - 1) / 32;
      eseg = (pp != 0) ? es[ii] : 7'd0;
      enb  = (pp != 0) ? en[ii] : 7'd0;
      n_cmp++;
      if (seg !== eseg) begin n_bad++; $display("FAIL dash_seg n=%0d: got %b, want %b", n, seg, eseg); end
      n_cmp++;
      if (nb_seg !== enb) begin n_bad++; $display("FAIL dash_nb_seg n=%0d: got %b, want %b", n, nb_seg, enb); end
    end
  endtask

  // brightness 0 lights only p=1; brightness 7 lights p=1..15
  task automatic test_brightness();
    logic [3:0] ea;
    int pp, ii, lim, lit_cnt, want_cnt;
    bcd_in = 16'h1234; dp_in = 4'h0;
    for (int b = 0; b < 2; b++) begin
      brightness = (b == 0) ? 4'd0 : 4'd7;
      lim        = (b == 0) ? 1 : 15;
      want_cnt   = (b == 0) ? 4 : 60;
      lit_cnt    = 0;
      do_reset();
      for (int n = 1; n <= 128; n++) begin
        @(negedge clk);
        pp = (n - 1) % 32;
        ii = (n - 1) / 32;
        ea = (pp >= 1 && pp <= lim) ? (4'b0001 << ii) : 4'b0000;
        if (an != 4'b0000) lit_cnt++;
        n_cmp++;
        if (an !== ea) begin n_bad++; $display("FAIL bright%0d_an n=%0d: got %b, want %b", lim, n, an, ea); end
      end
      n_cmp++;
      if (lit_cnt != want_cnt) begin
        n_bad++;
        $display("FAIL bright%0d_count: got %0d lit cycles, want %0d", lim, lit_cnt, want_cnt);
      end
    end
  endtask

  // input change mid-frame shows only after the next frame_tick
  task automatic test_snapshot();
    logic [6:0] eo [4];
    logic [6:0] enw [4];
    logic [6:0] eseg;
    logic       eft;
    int pp, ii;
    eo  = '{7'b1101111, 7'd0, 7'd0, 7'd0};
    enw = '{7'b0111111, 7'b0000110, 7'd0, 7'd0};
    bcd_in = 16'h0009; dp_in = 4'h0; brightness = 4'd15;
    do_reset();
    for (int n = 1; n <= 256; n++) begin
      @(negedge clk);
      pp = (n - 1) % 32;
      ii = ((n - 1) / 32) % 4;
      eseg = (pp == 0) ? 7'd0 : (n <= 128) ? eo[ii] : enw[ii];
      eft  = (n == 1) || (n == 128) || (n == 256);
      n_cmp++;
      if (seg !== eseg) begin n_bad++; $display("FAIL snap_seg n=%0d: got %b, want %b", n, seg, eseg); end
      n_cmp++;
      if (frame_tick !== eft) begin n_bad++; $display("FAIL snap_ft n=%0d: got %b, want %b", n, frame_tick, eft); end
      if (n == 40) bcd_in = 16'h0010;
    end
  endtask

  // one-cycle reset while a digit is lit, then a fresh scan of 5678
  task automatic test_reset_midscan();
    logic [6:0] es [4];
    logic [3:0] ea;
    logic [6:0] eseg;
    logic       eft;
    int pp, ii;
    es = '{7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101};
    bcd_in = 16'h1234; dp_in = 4'hF; brightness = 4'd15;
    do_reset();
    repeat (50) @(negedge clk);
    n_cmp++;
    if (an !== 4'b0010) begin n_bad++; $display("FAIL mid_prelit_an: got %b, want 0010", an); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({an, seg, dp, frame_tick} !== 13'b0) begin
      n_bad++;
      $display("FAIL mid_reset_main: got an=%b seg=%b dp=%b ft=%b, want all 0", an, seg, dp, frame_tick);
    end
    n_cmp++;
    if ({al_an, al_seg, al_dp} !== 12'hFFF) begin
      n_bad++;
      $display("FAIL mid_reset_al: got an=%b seg=%b dp=%b, want all 1", al_an, al_seg, al_dp);
    end
    reset = 1'b1;
    bcd_in = 16'h5678; dp_in = 4'h0;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      pp = (n - 1) % 32;
      ii = (n - 1) / 32;
      ea   = (pp != 0) ? (4'b0001 << ii) : 4'b0000;
      eseg = (pp != 0) ? es[ii] : 7'd0;
      eft  = (n == 1);
      n_cmp++;
      if (an !== ea) begin n_bad++; $display("FAIL mid_an n=%0d: got %b, want %b", n, an, ea); end
      n_cmp++;
      if (seg !== eseg) begin n_bad++; $display("FAIL mid_seg n=%0d: got %b, want %b", n, seg, eseg); end
      n_cmp++;
      if (dp !== 1'b0) begin n_bad++; $display("FAIL mid_dp n=%0d: got %b, want 0", n, dp); end
      n_cmp++;
      if (frame_tick !== eft) begin n_bad++; $display("FAIL mid_ft n=%0d: got %b, want %b", n, frame_tick, eft); end
      n_cmp++;
      if (al_seg !== ~eseg) begin n_bad++; $display("FAIL mid_al_seg n=%0d: got %b, want %b", n, al_seg, ~eseg); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_dash();
    test_brightness();
    test_snapshot();
    test_reset_midscan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by time limit, want completion");
    $fatal(1);
  end

endmodule

// File: doc/bcd_7seg_scanner.md
Name: bcd_7seg_scanner

Overview:
- Consumes packed BCD digits from the score counters and drives a time-multiplexed common-anode/common-cathode 7-segment display.
- Scans one digit per refresh slot and latches a coherent snapshot of all digits once per frame, so ripple-carry counter updates never tear.
- Applies leading-zero blanking, shows a dash for invalid BCD codes, and dims the display by PWM within each slot.
- Sits between the score counters and the board's display pins.

Parameters:
- NUM_DIGITS, 4: digits scanned per frame (2..8).
- REFRESH_DIV, 1000: clk cycles per digit slot (>=16).
- ACTIVE_LOW_OUT, 1: 1 = seg, dp and an are active-low at the pins; 0 = active-high.
- BLANK_LEADING, 1: 1 = leading-zero blanking enabled.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low; sampled on rising clk.
- bcd_in  in  4*NUM_DIGITS  packed digits; [3:0] = digit 0 (least significant).
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- brightness  in  4  PWM level; 0 = dimmest, 15 = full.
- seg  out  7  segments; bit0 = a … bit6 = g.
- dp  out  1  decimal point segment.
- an  out  NUM_DIGITS  digit enables; bit k selects digit k.
- frame_tick  out  1  one-cycle pulse when a new snapshot is loaded.

Behaviour:
- Internal state: prescaler p (0..REFRESH_DIV-1), digit index i (0..NUM_DIGITS-1), shadow digits and dp, primed flag.
- In this section "on" and "off" are logical levels. ACTIVE_LOW_OUT inverts seg, dp and an at the output registers only.
- Reset (reset=0 at a clk edge):
  - p=0, i=0, shadow=0, primed=0, frame_tick=0.
  - seg, dp and an are all off, i.e. all-ones at the pins when ACTIVE_LOW_OUT=1.
  - Reset mid-scan aborts the frame immediately; no partial digit remains lit.
- Prescaler and index:
  - p increments every cycle and wraps at REFRESH_DIV-1.
  - i advances on the p wrap and wraps from NUM_DIGITS-1 to 0.
- Snapshot:
  - shadow <= {bcd_in, dp_in} and frame_tick=1 on (a) the first cycle with reset=1 while primed=0, which then sets primed=1, or (b) the cycle where p=REFRESH_DIV-1 and i=NUM_DIGITS-1.
  - Input changes at any other time have no effect until the next load.
- Lit condition for slot i: p != 0 (one-cycle anti-ghost guard) AND p*16 < (brightness+1)*REFRESH_DIV.
  - brightness is sampled every cycle.
  - Arithmetic is unsigned, wide enough that no overflow occurs.
- Digit decode (shadow digit d):
  - 0-9 use the standard patterns. 1 = b,c; 7 = a,b,c; 6 and 9 include tail segments a and d respectively.
  - 10-15 display a dash (g only).
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit k>0 is blanked when it and every higher digit equal 0.
  - Digit 0 is never blanked.
  - Invalid codes count as non-zero.
  - Blanking suppresses seg only; dp still follows shadow dp.
- Outputs are registered, 1-cycle latency: seg/dp/an at edge t+1 reflect p, i, shadow and brightness at edge t.
  - When lit: an = one-hot(i), seg = pattern, dp = shadow dp[i].
  - When not lit: an, seg and dp are all off.
- Exactly one or zero an bits are on in any cycle.
- frame_tick is registered alongside the load; it is high for exactly one cycle per frame (NUM_DIGITS*REFRESH_DIV cycles) plus the post-reset load.

Test Plan:
- Bench configuration: NUM_DIGITS=4, REFRESH_DIV=32, ACTIVE_LOW_OUT=0.
- Reset then release with bcd_in=16'h1234, brightness=15 -> frame_tick pulses on the first released cycle; in each slot an is off in the first output cycle, then one-hot lit for 31 cycles. Digit 0 shows "4" (seg=7'b1100110), digit 3 shows "1" (seg=7'b0000110). Frame period is 128 cycles.
- bcd_in=16'h0007, dp_in=4'b0100 -> digit 0 shows "7" (7'b0000111). Digits 3 and 1 have seg=0. Digit 2 has seg=0 and dp=1. With BLANK_LEADING=0, digits 1-3 show "0" (7'b0111111).
- bcd_in=16'h00A0 -> digit 1 shows dash (7'b1000000). Digit 0 shows "0" (not blanked). Digits 2-3 are blanked.
- brightness=0 -> each slot is lit only at p=1, i.e. one output cycle per slot. brightness=7 -> lit for p=1..15.
- Change bcd_in from 16'h0009 to 16'h0010 in mid-frame -> the current frame still shows 0009. The new value appears only after the next frame_tick.
- Assert reset for one cycle mid-slot -> the next output cycle has an=0, seg=0, dp=0. Scanning restarts at i=0 with a fresh snapshot. Repeat with ACTIVE_LOW_OUT=1 and check all pins are at 1 during reset.
